// File: rtl/ee354_detour_pkg.sv
// Shared types and constants for the detour-sign front-end and the detour state machine.
package ee354_detour_pkg;

  typedef enum logic [2:0] {
    INI  = 3'd0,
    WQ   = 3'd1,
    SCEN = 3'd2,
    CCR  = 3'd3,
    WFCR = 3'd4
  } deb_state_e;

  localparam int unsigned DEF_DEB_CYCLES  = 1000000;
  localparam int unsigned DEF_STEP_CYCLES = 25000000;
  localparam int unsigned DEF_CNT_W       = 25;

  localparam logic DIR_LEFT  = 1'b1;
  localparam logic DIR_RIGHT = 1'b0;

  typedef struct packed {
    logic change;
    logic dir;
  } dir_req_t;

  // Coincident pulses cancel; a request for the current direction is not a change.
  function automatic dir_req_t dir_decode(input logic l_pulse, input logic r_pulse,
                                          input logic cur_dir);
    dir_req_t req;
    req.dir = cur_dir;
    if (l_pulse && !r_pulse) begin
      req.dir = DIR_LEFT;
    end else if (r_pulse && !l_pulse) begin
      req.dir = DIR_RIGHT;
    end
    req.change = (req.dir != cur_dir);
    return req;
  endfunction

endpackage

// File: rtl/ee354_detour_debounce.sv
// Two-flop synchronizer plus debounce FSM; emits one pulse per accepted press.
module ee354_detour_debounce
  import ee354_detour_pkg::*;
#(
  parameter int unsigned DEB_CYCLES = DEF_DEB_CYCLES,
  parameter int unsigned CNT_W      = DEF_CNT_W
) (
  input  logic       Clk,
  input  logic       reset,
  input  logic       Btn_raw,
  output logic       Btn_pulse,
  output deb_state_e q_state
);

  localparam logic [CNT_W-1:0] DebLast = CNT_W'(DEB_CYCLES - 1);

  if (DEB_CYCLES < 1) begin : g_bad_deb
    $error("DEB_CYCLES must be at least 1");
  end

  logic             r_sync1;
  logic             r_sync2;
  deb_state_e       r_state;
  deb_state_e       w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;

  always_ff @(posedge Clk) begin
    if (reset) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= Btn_raw;
      r_sync2 <= r_sync1;
    end
  end

  always_ff @(posedge Clk) begin
    if (reset) begin
      r_state <= INI;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    unique case (r_state)
      INI: begin
        w_cnt_nxt = '0;
        if (r_sync2) begin
          w_state_nxt = WQ;
        end
      end
      WQ: begin
        if (!r_sync2) begin
          w_state_nxt = INI;
          w_cnt_nxt   = '0;
        end else if (r_cnt == DebLast) begin
          w_state_nxt = SCEN;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      // The pulse cycle ignores the input; release tracking starts from CCR.
      SCEN: begin
        w_state_nxt = CCR;
        w_cnt_nxt   = '0;
      end
      CCR: begin
        w_cnt_nxt = '0;
        if (!r_sync2) begin
          w_state_nxt = WFCR;
        end
      end
      WFCR: begin
        if (r_sync2) begin
          w_state_nxt = CCR;
          w_cnt_nxt   = '0;
        end else if (r_cnt == DebLast) begin
          w_state_nxt = INI;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      default: begin
        w_state_nxt = INI;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  assign Btn_pulse = (r_state == SCEN);
  assign q_state   = r_state;

endmodule

// File: rtl/ee354_detour_dir_ctrl.sv
// Button front-end for the detour sign: debounced direction latch and a step pacer that
// restarts on every direction change.
module ee354_detour_dir_ctrl
  import ee354_detour_pkg::*;
#(
  parameter int unsigned DEB_CYCLES  = DEF_DEB_CYCLES,
  parameter int unsigned STEP_CYCLES = DEF_STEP_CYCLES,
  parameter int unsigned CNT_W       = DEF_CNT_W
) (
  input  logic Clk,
  input  logic reset,
  input  logic BtnL,
  input  logic BtnR,
  output logic L_Rbar,
  output logic Step_En,
  output logic Dir_Changed
);

  localparam logic [CNT_W-1:0] StepLast = CNT_W'(STEP_CYCLES - 1);

  if (STEP_CYCLES < 2) begin : g_bad_step
    $error("STEP_CYCLES must be at least 2");
  end

  logic             w_l_pulse;
  logic             w_r_pulse;
  deb_state_e       w_l_state;
  deb_state_e       w_r_state;
  dir_req_t         w_req;
  logic             r_l_rbar;
  logic             r_dir_changed;
  logic [CNT_W-1:0] r_step_cnt;
  logic             w_step_wrap;

  ee354_detour_debounce #(
    .DEB_CYCLES(DEB_CYCLES),
    .CNT_W     (CNT_W)
  ) u_deb_l (
    .Clk      (Clk),
    .reset    (reset),
    .Btn_raw  (BtnL),
    .Btn_pulse(w_l_pulse),
    .q_state  (w_l_state)
  );

  ee354_detour_debounce #(
    .DEB_CYCLES(DEB_CYCLES),
    .CNT_W     (CNT_W)
  ) u_deb_r (
    .Clk      (Clk),
    .reset    (reset),
    .Btn_raw  (BtnR),
    .Btn_pulse(w_r_pulse),
    .q_state  (w_r_state)
  );

  assign w_req       = dir_decode(w_l_pulse, w_r_pulse, r_l_rbar);
  assign w_step_wrap = (r_step_cnt == StepLast);

  always_ff @(posedge Clk) begin
    if (reset) begin
      r_l_rbar      <= DIR_RIGHT;
      r_dir_changed <= 1'b0;
      r_step_cnt    <= '0;
    end else begin
      r_dir_changed <= w_req.change;
      if (w_req.change) begin
        r_l_rbar <= w_req.dir;
      end
      // A direction change restarts the period so the new sequence gets a full first step.
      if (w_req.change || w_step_wrap) begin
        r_step_cnt <= '0;
      end else begin
        r_step_cnt <= r_step_cnt + CNT_W'(1);
      end
    end
  end

  assign L_Rbar      = r_l_rbar;
  assign Dir_Changed = r_dir_changed;
  assign Step_En     = w_step_wrap;

  a_l_scen_once: assert property (@(posedge Clk) disable iff (reset)
    (w_l_state == SCEN) |=> (w_l_state == CCR));
  a_r_scen_once: assert property (@(posedge Clk) disable iff (reset)
    (w_r_state == SCEN) |=> (w_r_state == CCR));

endmodule

// File: tb/tb_ee354_detour_dir_ctrl.sv
// Bench for ee354_detour_dir_ctrl: directed scenarios plus random button traffic, all
// checked every cycle against a run-length behavioural model.
module tb_ee354_detour_dir_ctrl;

  localparam int unsigned DEB  = 4;
  localparam int unsigned STEP = 10;
  localparam int unsigned CW   = 25;

  logic Clk   = 1'b0;
  logic reset = 1'b1;
  logic BtnL  = 1'b0;
  logic BtnR  = 1'b0;
  logic L_Rbar;
  logic Step_En;
  logic Dir_Changed;

  ee354_detour_dir_ctrl #(
    .DEB_CYCLES (DEB),
    .STEP_CYCLES(STEP),
    .CNT_W      (CW)
  ) dut (
    .Clk        (Clk),
    .reset      (reset),
    .BtnL       (BtnL),
    .BtnR       (BtnR),
    .L_Rbar     (L_Rbar),
    .Step_En    (Step_En),
    .Dir_Changed(Dir_Changed)
  );

  always #10 Clk = ~Clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b, expected %b at %0t", name, act, exp, $time);
    end
  endtask

  // Model: each button has an accepted level and a count of consecutive sampled edges that
  // disagree with it; DEB+1 such edges flip the level, and an accepted press yields a pulse
  // followed by one edge during which the input is ignored.
  bit m_valid = 1'b0;
  bit m_l, m_dch, m_step;
  int m_cyc, m_base;
  bit d1[2], d2[2], held[2], dead[2], pulse[2];
  int run[2];
  bit chg, s, raw, newp;

  always @(posedge Clk) begin
    if (reset) begin
      m_valid = 1'b1;
      m_l = 0; m_dch = 0; m_step = 0; m_cyc = 0; m_base = 0;
      for (int b = 0; b < 2; b++) begin
        d1[b] = 0; d2[b] = 0; held[b] = 0; dead[b] = 0; pulse[b] = 0; run[b] = 0;
      end
    end else begin
      chg = 0;
      if (pulse[0] && !pulse[1] && !m_l) begin
        chg = 1; m_l = 1;
      end else if (pulse[1] && !pulse[0] && m_l) begin
        chg = 1; m_l = 0;
      end
      m_dch = chg;
      m_cyc++;
      if (chg) m_base = m_cyc;
      m_step = ((m_cyc - m_base) % STEP) == STEP - 1;
      for (int b = 0; b < 2; b++) begin
        raw = (b == 0) ? BtnL : BtnR;
        s = d2[b]; d2[b] = d1[b]; d1[b] = raw;
        newp = 0;
        if (dead[b]) begin
          dead[b] = 0; run[b] = 0;
        end else begin
          if (s != held[b]) run[b]++;
          else run[b] = 0;
          if (run[b] == DEB + 1) begin
            run[b] = 0;
            if (!held[b]) begin
              newp = 1; dead[b] = 1;
            end
            held[b] = ~held[b];
          end
        end
        pulse[b] = newp;
      end
    end
  end

  always @(negedge Clk) begin
    if (m_valid) begin
      check("model_l_rbar", L_Rbar, m_l);
      check("model_step_en", Step_En, m_step);
      check("model_dir_changed", Dir_Changed, m_dch);
    end
  end

  task automatic edges(input int n);
    repeat (n) @(posedge Clk);
    #1;
  endtask

  // Drive both buttons at a falling edge, then wait n rising edges (first one is edge 0).
  task automatic hold(input bit l, input bit r, input int n);
    @(negedge Clk);
    BtnL = l;
    BtnR = r;
    edges(n);
  endtask

  task automatic do_reset(input int n);
    @(negedge Clk);
    reset = 1'b1;
    BtnL  = 1'b0;
    BtnR  = 1'b0;
    repeat (n) @(posedge Clk);
    @(negedge Clk);
    reset = 1'b0;
  endtask

  initial begin
    // 1: reset then idle; Step_En in cycles 9, 19, 29 after release.
    repeat (2) @(posedge Clk);
    @(negedge Clk);
    reset = 1'b0;
    edges(8);
    check("t1_step_c8", Step_En, 1'b0);
    edges(1);
    check("t1_step_c9", Step_En, 1'b1);
    edges(10);
    check("t1_step_c19", Step_En, 1'b1);
    edges(10);
    check("t1_step_c29", Step_En, 1'b1);
    check("t1_l_rbar", L_Rbar, 1'b0);

    // 3: bouncy press never qualifies.
    hold(1, 0, 3);
    hold(0, 0, 1);
    hold(1, 0, 3);
    hold(0, 0, 12);
    check("t3_l_rbar", L_Rbar, 1'b0);

    // 2: clean left press.
    hold(1, 0, 7);
    check("t2_l_before_e7", L_Rbar, 1'b0);
    edges(1);
    check("t2_l_after_e7", L_Rbar, 1'b1);
    check("t2_dch_after_e7", Dir_Changed, 1'b1);
    edges(1);
    check("t2_dch_after_e8", Dir_Changed, 1'b0);
    edges(7);
    check("t2_step_e15", Step_En, 1'b0);
    edges(1);
    check("t2_step_e16", Step_En, 1'b1);
    edges(3);
    hold(0, 0, 12);

    // 4: redundant left, then right.
    hold(1, 0, 20);
    check("t4_l_redundant", L_Rbar, 1'b1);
    hold(0, 0, 12);
    hold(0, 1, 8);
    check("t4_l_after_r", L_Rbar, 1'b0);
    check("t4_dch_after_r", Dir_Changed, 1'b1);
    edges(12);
    hold(0, 0, 12);

    // 5: left to 1, then simultaneous presses must cancel.
    hold(1, 0, 15);
    hold(0, 0, 12);
    hold(1, 1, 20);
    check("t5_l_both", L_Rbar, 1'b1);

    // 6: bouncy release, press aborted by reset, then clean re-press.
    hold(0, 0, 2);
    hold(1, 1, 1);
    hold(0, 0, 10);
    check("t6_l_after_release", L_Rbar, 1'b1);
    hold(1, 0, 4);
    do_reset(1);
    check("t6_l_reset", L_Rbar, 1'b0);
    check("t6_step_reset", Step_En, 1'b0);
    check("t6_dch_reset", Dir_Changed, 1'b0);
    hold(0, 0, 12);
    check("t6_l_aborted", L_Rbar, 1'b0);
    hold(1, 0, 8);
    check("t6_l_repress", L_Rbar, 1'b1);
    edges(10);
    hold(0, 0, 12);

    // Random traffic, occasional resets.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 39) == 0) begin
        do_reset($urandom_range(1, 3));
      end else begin
        hold(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             ($urandom_range(0, 2) == 0) ? int'($urandom_range(6, 14))
                                         : int'($urandom_range(1, 4)));
      end
    end
    hold(0, 0, 12);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
